// File: rtl/fifo_wr_arbiter_if.sv
// Write-side bundle between the producers, the round-robin arbiter and the
// async FIFO write port. The master side is the environment (producers plus
// the FIFO full flag); the slave side is the arbiter itself.
interface fifo_wr_arbiter_if #(
  parameter int NUM_REQ   = 4,
  parameter int DATA_SIZE = 8,
  parameter int ID_W      = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
);

  logic [NUM_REQ-1:0]           req_valid;
  logic [NUM_REQ*DATA_SIZE-1:0] req_data;
  logic [NUM_REQ-1:0]           req_ready;
  logic                         wfull;
  logic                         winc;
  logic [DATA_SIZE-1:0]         wdata;
  logic [ID_W-1:0]              grant_id;
  logic                         busy;

  // Producers and the FIFO full flag drive into the arbiter
  modport master (
    output req_valid,
    output req_data,
    output wfull,
    input  req_ready,
    input  winc,
    input  wdata,
    input  grant_id,
    input  busy
  );

  // The arbiter consumes requests and drives the FIFO write port
  modport slave (
    input  req_valid,
    input  req_data,
    input  wfull,
    output req_ready,
    output winc,
    output wdata,
    output grant_id,
    output busy
  );

endinterface

// File: rtl/fifo_wr_arbiter.sv
// Round-robin write-port arbiter for the async FIFO write side.
// One producer owns the FIFO write port for a burst of up to MAX_BURST
// transfers; transfers are gated combinationally by wfull so the FIFO can
// never be overrun. A single IDLE cycle separates consecutive bursts, and the
// round-robin pointer advances past the previous owner on every release.
module fifo_wr_arbiter #(
  parameter int NUM_REQ   = 4,
  parameter int DATA_SIZE = 8,
  parameter int MAX_BURST = 4
) (
  input  logic              wclk_i,
  input  logic              wrst_n_i,
  fifo_wr_arbiter_if.slave  bus
);

  localparam int ID_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  // cnt is 8 bits wide, so the last beat of a 256-long burst is 255
  localparam logic [7:0]      LAST_CNT = 8'(MAX_BURST - 1);
  localparam logic [ID_W-1:0] LAST_ID  = ID_W'(NUM_REQ - 1);

  typedef enum logic {
    IDLE  = 1'b0,
    BURST = 1'b1
  } state_e;

  state_e            state_q, state_d;
  logic [ID_W-1:0]   owner_q, owner_d;
  logic [ID_W-1:0]   rr_ptr_q, rr_ptr_d;
  logic [7:0]        cnt_q, cnt_d;

  logic              sel_found;
  logic [ID_W-1:0]   sel_idx;
  logic              owner_valid;
  logic              xfer;
  logic              release_burst;

  logic [NUM_REQ-1:0]   ready_c;
  logic                 winc_c;
  logic                 busy_c;
  logic [DATA_SIZE-1:0] wdata_c;

  // Round-robin pick: first valid requester scanning upward from rr_ptr,
  // wrapping modulo NUM_REQ (which need not be a power of two)
  always_comb begin
    int              scan;
    logic [ID_W-1:0] scan_id;
    sel_found = 1'b0;
    sel_idx   = '0;
    scan      = 0;
    scan_id   = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      scan = int'(rr_ptr_q) + k;
      if (scan >= NUM_REQ) begin
        scan = scan - NUM_REQ;
      end
      scan_id = ID_W'(scan);
      if (!sel_found && bus.req_valid[scan_id]) begin
        sel_found = 1'b1;
        sel_idx   = scan_id;
      end
    end
  end

  // Owner's request and data are steered straight through to the FIFO port
  always_comb begin
    owner_valid = bus.req_valid[owner_q];
    wdata_c     = bus.req_data[owner_q*DATA_SIZE +: DATA_SIZE];
  end

  // Next-state and handshake outputs; reset forces every strobe low so an
  // abandoned burst can never leak a write
  always_comb begin
    state_d       = state_q;
    owner_d       = owner_q;
    rr_ptr_d      = rr_ptr_q;
    cnt_d         = cnt_q;
    ready_c       = '0;
    winc_c        = 1'b0;
    busy_c        = 1'b0;
    xfer          = 1'b0;
    release_burst = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (sel_found) begin
          owner_d = sel_idx;
          cnt_d   = 8'd0;
          state_d = BURST;
        end
      end

      BURST: begin
        busy_c           = 1'b1;
        xfer             = owner_valid & ~bus.wfull;
        winc_c           = xfer;
        ready_c[owner_q] = xfer;
        if (xfer) begin
          cnt_d = cnt_q + 8'd1;
        end
        // A full FIFO only stalls the burst; only the last beat or the
        // owner going idle hands the port back
        release_burst = (xfer && (cnt_q == LAST_CNT)) || !owner_valid;
        if (release_burst) begin
          state_d  = IDLE;
          rr_ptr_d = (owner_q == LAST_ID) ? '0 : owner_q + ID_W'(1);
          cnt_d    = 8'd0;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    if (!wrst_n_i) begin
      ready_c = '0;
      winc_c  = 1'b0;
      busy_c  = 1'b0;
    end
  end

  // State register with synchronous active-low reset
  always_ff @(posedge wclk_i) begin
    if (!wrst_n_i) begin
      state_q  <= IDLE;
      owner_q  <= '0;
      rr_ptr_q <= '0;
      cnt_q    <= 8'd0;
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      rr_ptr_q <= rr_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  assign bus.req_ready = ready_c;
  assign bus.winc      = winc_c;
  assign bus.busy      = busy_c;
  assign bus.wdata     = wdata_c;
  assign bus.grant_id  = owner_q;

  // Protocol invariants of the write port
  a_ready_onehot0 : assert property (@(posedge wclk_i) $onehot0(bus.req_ready));
  a_winc_busy     : assert property (@(posedge wclk_i) bus.winc |-> bus.busy);
  a_no_overrun    : assert property (@(posedge wclk_i) bus.wfull |-> !bus.winc);

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed bench for the round-robin FIFO write arbiter (NUM_REQ=4,
// DATA_SIZE=8, MAX_BURST=4). Requester i presents the constant byte
// 8'h11*(i+1) so the owner is visible on wdata.
module tb_fifo_wr_arbiter;

  localparam int NUM_REQ   = 4;
  localparam int DATA_SIZE = 8;
  localparam int MAX_BURST = 4;
  localparam int ID_W      = 2;

  logic wclk   = 1'b0;
  logic wrst_n = 1'b0;

  int checks = 0;
  int passes = 0;

  logic [7:0] dataOf [4] = '{8'h11, 8'h22, 8'h33, 8'h44};

  fifo_wr_arbiter_if #(.NUM_REQ(NUM_REQ), .DATA_SIZE(DATA_SIZE), .ID_W(ID_W)) bus ();

  fifo_wr_arbiter #(
    .NUM_REQ  (NUM_REQ),
    .DATA_SIZE(DATA_SIZE),
    .MAX_BURST(MAX_BURST)
  ) dut (
    .wclk_i  (wclk),
    .wrst_n_i(wrst_n),
    .bus     (bus)
  );

  // Free-running write clock, 10 time units per cycle
  always #5 wclk = ~wclk;

  task automatic next_cycle();
    @(posedge wclk);
    #1;
  endtask

  task automatic do_reset();
    wrst_n        = 1'b0;
    bus.req_valid = '0;
    bus.wfull     = 1'b0;
    next_cycle();
    wrst_n = 1'b1;
  endtask

  task automatic test_reset();
    wrst_n        = 1'b0;
    bus.req_valid = 4'hF;
    bus.wfull     = 1'b0;
    for (int i = 0; i < 3; i++) begin
      next_cycle();
      checks++; if (bus.req_ready !== 4'b0000) $display("[TB] FAIL reset_ready edge=%0d got=%b exp=0000", i, bus.req_ready); else passes++;
      checks++; if (bus.winc !== 1'b0) $display("[TB] FAIL reset_winc edge=%0d got=%b exp=0", i, bus.winc); else passes++;
      checks++; if (bus.busy !== 1'b0) $display("[TB] FAIL reset_busy edge=%0d got=%b exp=0", i, bus.busy); else passes++;
      checks++; if (bus.grant_id !== 2'd0) $display("[TB] FAIL reset_grant edge=%0d got=%0d exp=0", i, bus.grant_id); else passes++;
    end
    wrst_n = 1'b1;
    #1;
    checks++; if (bus.busy !== 1'b0) $display("[TB] FAIL reset_idle_busy got=%b exp=0", bus.busy); else passes++;
    next_cycle();
    checks++; if (bus.busy !== 1'b1) $display("[TB] FAIL reset_first_busy got=%b exp=1", bus.busy); else passes++;
    checks++; if (bus.grant_id !== 2'd0) $display("[TB] FAIL reset_first_grant got=%0d exp=0", bus.grant_id); else passes++;
    checks++; if (bus.winc !== 1'b1) $display("[TB] FAIL reset_first_winc got=%b exp=1", bus.winc); else passes++;
    checks++; if (bus.wdata !== 8'h11) $display("[TB] FAIL reset_first_wdata got=%h exp=11", bus.wdata); else passes++;
  endtask

  task automatic test_single();
    logic expWinc [11] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    do_reset();
    bus.req_valid = 4'b0100;
    for (int k = 0; k < 11; k++) begin
      #1;
      checks++; if (bus.winc !== expWinc[k]) $display("[TB] FAIL single_winc k=%0d got=%b exp=%b", k, bus.winc, expWinc[k]); else passes++;
      checks++; if (bus.req_ready !== (expWinc[k] ? 4'b0100 : 4'b0000)) $display("[TB] FAIL single_ready k=%0d got=%b exp=%b", k, bus.req_ready, expWinc[k] ? 4'b0100 : 4'b0000); else passes++;
      if (k >= 1) begin
        checks++; if (bus.grant_id !== 2'd2) $display("[TB] FAIL single_grant k=%0d got=%0d exp=2", k, bus.grant_id); else passes++;
      end
      if (expWinc[k]) begin
        checks++; if (bus.wdata !== 8'h33) $display("[TB] FAIL single_wdata k=%0d got=%h exp=33", k, bus.wdata); else passes++;
      end
      next_cycle();
    end
  endtask

  task automatic test_round_robin();
    int expGrant [25] = '{0, 0, 0, 0, 0,  0, 1, 1, 1, 1,  1, 2, 2, 2, 2,
                          2, 3, 3, 3, 3,  3, 0, 0, 0, 0};
    logic expWinc;
    do_reset();
    bus.req_valid = 4'b1111;
    for (int k = 0; k < 25; k++) begin
      #1;
      expWinc = ((k % 5) != 0);
      checks++; if (bus.winc !== expWinc) $display("[TB] FAIL rr_winc k=%0d got=%b exp=%b", k, bus.winc, expWinc); else passes++;
      checks++; if (bus.grant_id !== ID_W'(expGrant[k])) $display("[TB] FAIL rr_grant k=%0d got=%0d exp=%0d", k, bus.grant_id, expGrant[k]); else passes++;
      if (expWinc) begin
        checks++; if (bus.wdata !== dataOf[expGrant[k]]) $display("[TB] FAIL rr_wdata k=%0d got=%h exp=%h", k, bus.wdata, dataOf[expGrant[k]]); else passes++;
      end
      next_cycle();
    end
  endtask

  task automatic test_backpressure();
    logic expWinc [12] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
    logic expBusy [12] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
    do_reset();
    bus.req_valid = 4'b0010;
    for (int k = 0; k < 12; k++) begin
      bus.wfull = (k >= 3 && k <= 7);
      #1;
      checks++; if (bus.winc !== expWinc[k]) $display("[TB] FAIL bp_winc k=%0d got=%b exp=%b", k, bus.winc, expWinc[k]); else passes++;
      checks++; if (bus.busy !== expBusy[k]) $display("[TB] FAIL bp_busy k=%0d got=%b exp=%b", k, bus.busy, expBusy[k]); else passes++;
      checks++; if (bus.req_ready !== (expWinc[k] ? 4'b0010 : 4'b0000)) $display("[TB] FAIL bp_ready k=%0d got=%b exp=%b", k, bus.req_ready, expWinc[k] ? 4'b0010 : 4'b0000); else passes++;
      if (k >= 1) begin
        checks++; if (bus.grant_id !== 2'd1) $display("[TB] FAIL bp_grant k=%0d got=%0d exp=1", k, bus.grant_id); else passes++;
      end
      next_cycle();
    end
    bus.wfull = 1'b0;
  endtask

  task automatic test_early_release();
    do_reset();
    bus.req_valid = 4'b1000;
    next_cycle();
    #1;
    checks++; if (bus.winc !== 1'b1) $display("[TB] FAIL early_first_winc got=%b exp=1", bus.winc); else passes++;
    checks++; if (bus.wdata !== 8'h44) $display("[TB] FAIL early_first_wdata got=%h exp=44", bus.wdata); else passes++;
    next_cycle();
    bus.req_valid = 4'b0101;
    #1;
    checks++; if (bus.winc !== 1'b0) $display("[TB] FAIL early_drop_winc got=%b exp=0", bus.winc); else passes++;
    checks++; if (bus.req_ready !== 4'b0000) $display("[TB] FAIL early_drop_ready got=%b exp=0000", bus.req_ready); else passes++;
    checks++; if (bus.busy !== 1'b1) $display("[TB] FAIL early_drop_busy got=%b exp=1", bus.busy); else passes++;
    next_cycle();
    checks++; if (bus.busy !== 1'b0) $display("[TB] FAIL early_gap_busy got=%b exp=0", bus.busy); else passes++;
    checks++; if (bus.grant_id !== 2'd3) $display("[TB] FAIL early_gap_grant got=%0d exp=3", bus.grant_id); else passes++;
    next_cycle();
    checks++; if (bus.grant_id !== 2'd0) $display("[TB] FAIL early_regrant got=%0d exp=0", bus.grant_id); else passes++;
    checks++; if (bus.winc !== 1'b1) $display("[TB] FAIL early_regrant_winc got=%b exp=1", bus.winc); else passes++;
    checks++; if (bus.wdata !== 8'h11) $display("[TB] FAIL early_regrant_wdata got=%h exp=11", bus.wdata); else passes++;
  endtask

  task automatic test_mid_reset();
    do_reset();
    bus.req_valid = 4'b0100;
    next_cycle();
    #1;
    checks++; if (bus.grant_id !== 2'd2) $display("[TB] FAIL midrst_grant got=%0d exp=2", bus.grant_id); else passes++;
    checks++; if (bus.winc !== 1'b1) $display("[TB] FAIL midrst_winc_pre got=%b exp=1", bus.winc); else passes++;
    next_cycle();
    wrst_n        = 1'b0;
    bus.req_valid = 4'b0101;
    #1;
    checks++; if (bus.winc !== 1'b0) $display("[TB] FAIL midrst_winc got=%b exp=0", bus.winc); else passes++;
    checks++; if (bus.busy !== 1'b0) $display("[TB] FAIL midrst_busy got=%b exp=0", bus.busy); else passes++;
    checks++; if (bus.req_ready !== 4'b0000) $display("[TB] FAIL midrst_ready got=%b exp=0000", bus.req_ready); else passes++;
    next_cycle();
    wrst_n = 1'b1;
    #1;
    checks++; if (bus.busy !== 1'b0) $display("[TB] FAIL midrst_idle_busy got=%b exp=0", bus.busy); else passes++;
    checks++; if (bus.grant_id !== 2'd0) $display("[TB] FAIL midrst_idle_grant got=%0d exp=0", bus.grant_id); else passes++;
    next_cycle();
    checks++; if (bus.busy !== 1'b1) $display("[TB] FAIL midrst_regrant_busy got=%b exp=1", bus.busy); else passes++;
    checks++; if (bus.grant_id !== 2'd0) $display("[TB] FAIL midrst_regrant got=%0d exp=0", bus.grant_id); else passes++;
    checks++; if (bus.wdata !== 8'h11) $display("[TB] FAIL midrst_wdata got=%h exp=11", bus.wdata); else passes++;
  endtask

  // Scenario sequence
  initial begin
    bus.req_valid = '0;
    bus.req_data  = 32'h44332211;
    bus.wfull     = 1'b0;
    test_reset();
    test_single();
    test_round_robin();
    test_backpressure();
    test_early_release();
    test_mid_reset();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/fifo_wr_arbiter.md
Name: fifo_wr_arbiter

Overview:
- Round-robin write-port arbiter that lets NUM_REQ producers in the write clock domain share the single write port of the asynchronous FIFO.
- Grants one requester at a time for a bounded burst, gates transfers on wfull, and drives the FIFO winc/wdata.
- Sits between producer blocks and fifo_top's write side; runs entirely on wclk.

Parameters:
- NUM_REQ, 4, number of requesters; legal range 2..16, need not be a power of two.
- DATA_SIZE, 8, data width; matches the FIFO DATA_SIZE.
- MAX_BURST, 4, maximum transfers per grant; legal range 1..256.

Ports:
- wclk  input  1  write-domain clock; all state updates on the rising edge.
- wrst_n  input  1  synchronous active-low reset, sampled on the rising edge of wclk.
- req_valid  input  NUM_REQ  per-requester data valid.
- req_data  input  NUM_REQ*DATA_SIZE  packed data; requester i occupies bits [i*DATA_SIZE +: DATA_SIZE].
- req_ready  output  NUM_REQ  per-requester accept; at most one bit high.
- wfull  input  1  FIFO full flag, registered in the wclk domain.
- winc  output  1  FIFO write enable.
- wdata  output  DATA_SIZE  FIFO write data.
- grant_id  output  ID_W  current owner index; ID_W = max(1, clog2(NUM_REQ)).
- busy  output  1  high while state is BURST.

Behaviour:
- Registered state: state {IDLE, BURST}, owner (ID_W bits), rr_ptr (ID_W bits), cnt (8 bits).
- Reset (wrst_n low at a wclk edge): state=IDLE, owner=0, rr_ptr=0, cnt=0.
  - Combinational outputs req_ready, winc and busy are forced 0 while wrst_n is low.
  - grant_id=0 after reset.
  - Reset mid-burst abandons the burst; no partial-state carryover.
- IDLE:
  - req_ready=0, winc=0.
  - If any req_valid bit is set, select the first index i scanning rr_ptr, rr_ptr+1, ... modulo NUM_REQ.
  - On that selection: owner<=i, cnt<=0, state<=BURST.
  - If no req_valid bit is set, stay in IDLE.
- BURST:
  - req_ready[owner] = req_valid[owner] & ~wfull; all other ready bits are 0.
  - Transfer: xfer = req_valid[owner] & ~wfull.
  - winc = xfer (combinational, same cycle). wdata = req_data slice for owner, driven whenever busy; don't-care otherwise.
  - No registering on the write path, so a registered wfull can never be overrun.
  - On xfer: cnt<=cnt+1.
  - Release condition: (xfer & cnt==MAX_BURST-1) OR ~req_valid[owner].
  - On release: state<=IDLE, rr_ptr<=(owner+1) mod NUM_REQ (explicit wrap at NUM_REQ-1 -> 0), cnt<=0.
  - wfull high with the owner still valid: hold. No transfer, cnt unchanged, grant kept indefinitely. Full backpressure never causes a release.
- Timing:
  - One IDLE cycle always separates consecutive bursts.
  - Latency from req_valid rising (arbiter idle) to the first winc is 1 cycle.
- grant_id = owner at all times. busy = (state==BURST).
- Fairness: a requester that is continuously valid is granted within NUM_REQ-1 other bursts.
- Requesters may drop valid at any time without protocol error.
- Data on req_data is sampled only in an xfer cycle.

Test Plan:
- Reset: hold wrst_n=0 for 3 edges with all req_valid=1 -> req_ready=0, winc=0, busy=0, grant_id=0. First edge after release -> busy=1, grant_id=0.
- Single requester: req_valid=4'b0100 continuously, wfull=0, MAX_BURST=4 -> four consecutive winc with wdata = req_data[23:16], then 1 idle cycle, then regrant to 2. Pattern repeats 4 on / 1 off.
- Round robin: all 4 valid continuously -> grant_id sequence 0,1,2,3,0, each burst exactly 4 winc pulses with 1 gap cycle. A 5th grant to index 0 confirms wrap.
- Backpressure: owner 1 mid-burst at cnt=2, assert wfull for 5 cycles -> winc=0 and req_ready=0 during those cycles, grant_id stays 1. After wfull drops, exactly 2 more writes complete, then release.
- Early release: owner 3 drops req_valid after 1 transfer while 0 and 2 are valid -> return to IDLE, rr_ptr=0, next grant_id=0 (wrap from 3).
- Mid-burst reset: wrst_n=0 for 1 edge during owner 2 at cnt=1 -> winc=0 that cycle, state IDLE. Next grant scans from index 0.
